run_length_detector: RTL and testbench

- Moore-style sequence detector on serial input w.
- Flags when w has held the same value for RUN_LEN or more consecutive enabled samples.
- Polarity filtering (ones, zeros, both) via a mode input, a saturating run counter, and a one-cycle detect pulse.
- Drop-in generalisation of the team's "two equal inputs in a row" detector for the lab FSM datapath; with RUN_LEN=2 and mode=00 it produces the same z sequence.

---
 rtl/run_length_detector_if.sv | 27 ++
 rtl/run_length_detector.sv | 82 ++++++++
 tb/tb_run_length_detector.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/run_length_detector_if.sv
// Bus bundle for run_length_detector.
// master: drives en/w/mode and observes the detector outputs.
// slave : the detector side; consumes en/w/mode and drives
//         z, z_ones, z_zeros, z_pulse, run_count and state.
interface run_length_detector_if #(
    parameter int unsigned CNT_W = 4
) ();
    logic             en;
    logic             w;
    logic [1:0]       mode;
    logic             z;
    logic             z_ones;
    logic             z_zeros;
    logic             z_pulse;
    logic [CNT_W-1:0] run_count;
    logic [1:0]       state;

    modport master (
        output en, w, mode,
        input  z, z_ones, z_zeros, z_pulse, run_count, state
    );

    modport slave (
        input  en, w, mode,
        output z, z_ones, z_zeros, z_pulse, run_count, state
    );
endinterface

// File: rtl/run_length_detector.sv
// Run-length detector: flags when the serial input w has held the same value
// for RUN_LEN or more consecutive enabled samples.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset
//   bus   - slave side of run_length_detector_if
//           (en, w, mode in; z, z_ones, z_zeros, z_pulse, run_count, state out)
module run_length_detector #(
    parameter int unsigned RUN_LEN = 2,
    parameter int unsigned CNT_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    run_length_detector_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ZERO_RUN = 2'b01,
        ST_ONE_RUN  = 2'b10,
        ST_UNUSED   = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] LEN_M1    = CNT_W'(RUN_LEN - 1);
    localparam bit               LEN_IS_1  = (RUN_LEN == 1);

    state_e           st;
    logic [CNT_W-1:0] cnt;
    logic             pulse;

    logic ones_ok;
    logic zeros_ok;
    logic allow_next;
    logic same_run;

    // Polarity filter from the live mode input.
    assign ones_ok    = (bus.mode == 2'b00) || (bus.mode == 2'b01);
    assign zeros_ok   = (bus.mode == 2'b00) || (bus.mode == 2'b10);
    assign allow_next = bus.w ? ones_ok : zeros_ok;
    assign same_run   = ((st == ST_ONE_RUN) && bus.w) || ((st == ST_ZERO_RUN) && !bus.w);

    // Run FSM with saturating counter and first-reach pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            st    <= ST_IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            case (st)
                ST_UNUSED: begin
                    st  <= ST_IDLE;
                    cnt <= '0;
                end
                default: begin
                    if (bus.en) begin
                        if (same_run) begin
                            if (cnt != CNT_MAX) begin
                                cnt <= cnt + CNT_W'(1);
                            end
                            // Saturated count never equals RUN_LEN-1, so no re-pulse.
                            pulse <= (cnt == LEN_M1) && allow_next;
                        end else begin
                            st    <= bus.w ? ST_ONE_RUN : ST_ZERO_RUN;
                            cnt   <= CNT_W'(1);
                            pulse <= LEN_IS_1 && allow_next;
                        end
                    end
                end
            endcase
        end
    end

    // Level outputs follow registered state and live mode.
    assign bus.z_ones    = (st == ST_ONE_RUN)  && (cnt >= RUN_LEN_C);
    assign bus.z_zeros   = (st == ST_ZERO_RUN) && (cnt >= RUN_LEN_C);
    assign bus.z         = (bus.z_ones && ones_ok) || (bus.z_zeros && zeros_ok);
    assign bus.z_pulse   = pulse;
    assign bus.run_count = cnt;
    assign bus.state     = st;
endmodule

// File: tb/tb_run_length_detector.sv
// Randomized and directed bench for run_length_detector; four parameter sets
// share one stimulus stream and are compared against a run-length model.
module tb_run_length_detector;
    localparam int NDUT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       w;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;

    // Per-instance parameters: RUN_LEN and counter max.
    int rl   [NDUT];
    int cmax [NDUT];

    // Reference model: last value and unbounded run length.
    bit m_valid [NDUT];
    bit m_val   [NDUT];
    int m_len   [NDUT];
    bit m_pulse [NDUT];

    logic [NDUT-1:0] o_z, o_zo, o_zz, o_p;
    logic [3:0]      o_cnt [NDUT];
    logic [1:0]      o_st  [NDUT];

    always #5 clk = ~clk;

    run_length_detector_if #(.CNT_W(4)) b0 ();
    run_length_detector_if #(.CNT_W(4)) b1 ();
    run_length_detector_if #(.CNT_W(2)) b2 ();
    run_length_detector_if #(.CNT_W(4)) b3 ();

    assign b0.en = en; assign b0.w = w; assign b0.mode = mode;
    assign b1.en = en; assign b1.w = w; assign b1.mode = mode;
    assign b2.en = en; assign b2.w = w; assign b2.mode = mode;
    assign b3.en = en; assign b3.w = w; assign b3.mode = mode;

    run_length_detector #(.RUN_LEN(2), .CNT_W(4)) u0 (.clk(clk), .reset(reset), .bus(b0));
    run_length_detector #(.RUN_LEN(3), .CNT_W(4)) u1 (.clk(clk), .reset(reset), .bus(b1));
    run_length_detector #(.RUN_LEN(3), .CNT_W(2)) u2 (.clk(clk), .reset(reset), .bus(b2));
    run_length_detector #(.RUN_LEN(1), .CNT_W(4)) u3 (.clk(clk), .reset(reset), .bus(b3));

    assign o_z  = {b3.z, b2.z, b1.z, b0.z};
    assign o_zo = {b3.z_ones, b2.z_ones, b1.z_ones, b0.z_ones};
    assign o_zz = {b3.z_zeros, b2.z_zeros, b1.z_zeros, b0.z_zeros};
    assign o_p  = {b3.z_pulse, b2.z_pulse, b1.z_pulse, b0.z_pulse};
    assign o_cnt[0] = b0.run_count;
    assign o_cnt[1] = b1.run_count;
    assign o_cnt[2] = 4'(b2.run_count);
    assign o_cnt[3] = b3.run_count;
    assign o_st[0] = b0.state;
    assign o_st[1] = b1.state;
    assign o_st[2] = b2.state;
    assign o_st[3] = b3.state;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit allowed(input bit val, input logic [1:0] m);
        return (m == 2'b00) || (m == 2'b01 && val) || (m == 2'b10 && !val);
    endfunction

    // Advance the model by one clock edge with the given inputs.
    task automatic model_edge(input bit r, input bit e, input bit wv, input logic [1:0] m);
        for (int i = 0; i < NDUT; i++) begin
            if (r) begin
                m_valid[i] = 1'b0;
                m_len[i]   = 0;
                m_pulse[i] = 1'b0;
            end else if (e) begin
                if (!m_valid[i] || m_val[i] != wv) begin
                    m_valid[i] = 1'b1;
                    m_val[i]   = wv;
                    m_len[i]   = 1;
                end else begin
                    m_len[i]++;
                end
                // Unbounded length hits RUN_LEN exactly once per run.
                m_pulse[i] = (m_len[i] == rl[i]) && allowed(wv, m);
            end else begin
                m_pulse[i] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NDUT; i++) begin
            int st_e, cnt_e;
            bit zo, zz, ze;
            st_e  = m_valid[i] ? (m_val[i] ? 2 : 1) : 0;
            cnt_e = m_valid[i] ? ((m_len[i] > cmax[i]) ? cmax[i] : m_len[i]) : 0;
            zo    = m_valid[i] && m_val[i] && (m_len[i] >= rl[i]);
            zz    = m_valid[i] && !m_val[i] && (m_len[i] >= rl[i]);
            ze    = (zo && (mode == 2'b00 || mode == 2'b01)) || (zz && (mode == 2'b00 || mode == 2'b10));
            check($sformatf("dut%0d state", i),     32'(o_st[i]),  32'(st_e));
            check($sformatf("dut%0d run_count", i), 32'(o_cnt[i]), 32'(cnt_e));
            check($sformatf("dut%0d z_ones", i),    32'(o_zo[i]),  32'(zo));
            check($sformatf("dut%0d z_zeros", i),   32'(o_zz[i]),  32'(zz));
            check($sformatf("dut%0d z", i),         32'(o_z[i]),   32'(ze));
            check($sformatf("dut%0d z_pulse", i),   32'(o_p[i]),   32'(m_pulse[i]));
        end
    endtask

    task automatic step(input bit r, input bit e, input bit wv, input logic [1:0] m);
        @(negedge clk);
        reset = r; en = e; w = wv; mode = m;
        @(posedge clk);
        model_edge(r, e, wv, m);
        #1;
        check_all();
    endtask

    task automatic live_mode(input logic [1:0] m);
        mode = m;
        #1;
        check_all();
    endtask

    initial begin
        bit [5:0] t1_w, t1_z, t1_p;
        bit       rw;
        logic [1:0] rm;
        rl   = '{2, 3, 3, 1};
        cmax = '{15, 15, 3, 15};
        reset = 1'b1; en = 1'b0; w = 1'b0; mode = 2'b00;

        step(1, 0, 0, 2'b00);

        // Test 1: w=0,0,1,1,1,0 with fixed expected z / z_pulse on RUN_LEN=2.
        t1_w = 6'b001110;
        t1_z = 6'b010110;
        t1_p = 6'b010100;
        for (int k = 0; k < 6; k++) begin
            step(0, 1, t1_w[5-k], 2'b00);
            check($sformatf("t1 z[%0d]", k),       32'(o_z[0]), 32'(t1_z[5-k]));
            check($sformatf("t1 z_pulse[%0d]", k), 32'(o_p[0]), 32'(t1_p[5-k]));
        end

        // Test 2: ones-only mode, zeros then ones.
        step(1, 1, 0, 2'b01);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 2'b01);
        for (int k = 0; k < 3; k++) step(0, 1, 1, 2'b01);

        // Test 3: long ones run to saturation, then a zero.
        step(1, 1, 0, 2'b00);
        for (int k = 0; k < 17; k++) step(0, 1, 1, 2'b00);
        step(0, 1, 0, 2'b00);

        // Test 4: enable gating.
        step(1, 0, 0, 2'b00);
        step(0, 1, 1, 2'b00);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 2'b00);
        step(0, 1, 1, 2'b00);

        // Test 5: mid-run reset.
        step(1, 1, 1, 2'b00);
        step(0, 1, 1, 2'b00);

        // Test 6: live mode changes on a ones run of length 3.
        step(0, 1, 1, 2'b00);
        step(0, 1, 1, 2'b00);
        step(0, 0, 0, 2'b00);
        live_mode(2'b10);
        live_mode(2'b11);
        live_mode(2'b01);
        live_mode(2'b00);

        // Randomized runs: sticky w, occasional enable drop, rare reset.
        rw = 1'b0;
        rm = 2'b00;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(3, 0) == 0) rw = ~rw;
            if ($urandom_range(9, 0) == 0) rm = 2'($urandom_range(3, 0));
            step(($urandom_range(49, 0) == 0), ($urandom_range(4, 0) != 0), rw, rm);
            if ($urandom_range(19, 0) == 0) live_mode(2'($urandom_range(3, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
